// File: rtl/timing_sequencer.sv
// Machine-cycle phase sequencer: one-hot T0..T7 with memory stretch, early end, run/halt/step.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module timing_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             step,
  input  logic             mem_ready,
  input  logic             short_cycle,
  output logic [7:0]       t,
  output logic             busy,
  output logic             halted,
  output logic             cycle_done,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {StIdle, StRun, StWait, StStep, StHalt} state_e;

  localparam logic [7:0] PhaseT0   = 8'h01;
  localparam logic [7:0] WaitLimit = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] t_q, t_d;
  logic [7:0] wait_q, wait_d;
  logic       halt_q, halt_d;
  logic       timeout_q, timeout_d;
  logic       halt_pend;
  logic       boundary;

  // A halt request seen on the boundary cycle itself still counts.
  assign halt_pend = halt_q | halt_req;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    wait_d    = wait_q;
    halt_d    = halt_pend;
    timeout_d = timeout_q & ~run;
    boundary  = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (run) begin
          state_d = StRun;
          t_d     = PhaseT0;
        end
      end
      StRun: begin
        if ((t_q[1] || t_q[4]) && !mem_ready) begin
          state_d = StWait;
          wait_d  = 8'd1;
        end else if (t_q[7] || (t_q[5] && short_cycle)) begin
          boundary = 1'b1;
          if (halt_pend) begin
            state_d = StHalt;
            t_d     = '0;
            halt_d  = 1'b0;
          end else if (step_mode) begin
            state_d = StStep;
            t_d     = '0;
          end else begin
            t_d = PhaseT0;
          end
        end else begin
          t_d = {t_q[6:0], 1'b0};
        end
      end
      StWait: begin
        if (mem_ready) begin
          state_d = StRun;
          t_d     = {t_q[6:0], 1'b0};
          wait_d  = '0;
        end else if (wait_q >= WaitLimit) begin
          // Abort: no boundary, so the instruction is not counted.
          state_d   = StHalt;
          t_d       = '0;
          wait_d    = '0;
          timeout_d = 1'b1;
          halt_d    = 1'b0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StStep: begin
        if (halt_pend) begin
          state_d = StHalt;
          halt_d  = 1'b0;
        end else if (step || (run && !step_mode)) begin
          state_d = StRun;
          t_d     = PhaseT0;
        end
      end
      default: begin
        state_d = StIdle;
        t_d     = '0;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      wait_q    <= wait_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
    end
  end

  assign t          = t_q;
  assign busy       = (state_q == StRun) || (state_q == StWait);
  assign halted     = (state_q == StIdle) || (state_q == StHalt);
  assign cycle_done = (t_q[5] & short_cycle) | t_q[7];
  assign timeout    = timeout_q;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (boundary) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_count = cnt_q;
`else
  logic unused_boundary;
  assign unused_boundary = boundary;
  assign instr_count     = '0;
`endif

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer; counter checks adapt to INSTR_COUNT_EN.
module tb_timing_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       halt_req = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       mem_ready = 1'b1;
  logic       short_cycle = 1'b0;
  logic [7:0] t;
  logic       busy, halted, cycle_done, timeout;
  logic [3:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;
  int retired = 0;

  timing_sequencer #(
    .WAIT_MAX(15),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .halt_req   (halt_req),
    .step_mode  (step_mode),
    .step       (step),
    .mem_ready  (mem_ready),
    .short_cycle(short_cycle),
    .t          (t),
    .busy       (busy),
    .halted     (halted),
    .cycle_done (cycle_done),
    .timeout    (timeout),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef INSTR_COUNT_EN
    return 4'(n);
`else
    return 4'(0 * n);
`endif
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".t"}, t, 8'h00);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".halted"}, halted, 1'b1);
    chk({tag, ".cycle_done"}, cycle_done, 1'b0);
    chk({tag, ".timeout"}, timeout, 1'b0);
    chk({tag, ".instr_count"}, instr_count, 4'h0);
  endtask

  initial begin
    // Reset state
    #3;
    chk_reset("reset");
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("idle_t", t, 8'h00);
    chk("idle_halted", halted, 1'b1);

    // 1: full 8-phase instruction, back-to-back start
    run = 1'b1;
    cyc();
    run = 1'b0;
    chk("t1_t0", t, 8'h01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_halted", halted, 1'b0);
    chk("t1_cd0", cycle_done, 1'b0);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("t1_walk", t, 8'h01 << i);
      chk("t1_cd", cycle_done, (i == 7));
    end
    cyc();
    retired++;
    chk("t1_wrap", t, 8'h01);
    chk("t1_count", instr_count, exp_cnt(retired));

    // 2: short instruction ends at T5
    short_cycle = 1'b1;
    repeat (5) cyc();
    chk("t2_t5", t, 8'h20);
    chk("t2_cd", cycle_done, 1'b1);
    cyc();
    retired++;
    chk("t2_next", t, 8'h01);
    chk("t2_count", instr_count, exp_cnt(retired));
    short_cycle = 1'b0;

    // 3a: three cycles of mem_ready=0 in T1 stretch T1 to four cycles
    cyc();
    chk("t3_t1", t, 8'h02);
    mem_ready = 1'b0;
    cyc();
    chk("t3_w1", t, 8'h02);
    chk("t3_busy", busy, 1'b1);
    cyc();
    chk("t3_w2", t, 8'h02);
    cyc();
    chk("t3_w3", t, 8'h02);
    mem_ready = 1'b1;
    cyc();
    chk("t3_t2", t, 8'h04);
    repeat (5) cyc();
    chk("t3_t7", t, 8'h80);
    cyc();
    retired++;
    chk("t3_count", instr_count, exp_cnt(retired));

    // 3b: mem_ready low for 16 cycles in T1 -> timeout abort
    cyc();
    chk("to_t1", t, 8'h02);
    mem_ready = 1'b0;
    repeat (15) cyc();
    chk("to_held", t, 8'h02);
    chk("to_notyet", timeout, 1'b0);
    chk("to_cd", cycle_done, 1'b0);
    cyc();
    chk("to_t", t, 8'h00);
    chk("to_timeout", timeout, 1'b1);
    chk("to_halted", halted, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_count", instr_count, exp_cnt(retired));
    mem_ready = 1'b1;

    // 4: halt_req pulse at T2 lets the instruction finish
    run = 1'b1;
    cyc();
    run = 1'b0;
    chk("t4_t0", t, 8'h01);
    chk("t4_to_clr", timeout, 1'b0);
    cyc();
    cyc();
    chk("t4_t2", t, 8'h04);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("t4_t3", t, 8'h08);
    repeat (4) cyc();
    chk("t4_t7", t, 8'h80);
    cyc();
    retired++;
    chk("t4_halt_t", t, 8'h00);
    chk("t4_halted", halted, 1'b1);
    chk("t4_count", instr_count, exp_cnt(retired));
    cyc();
    chk("t4_stay", t, 8'h00);
    run = 1'b1;
    cyc();
    run = 1'b0;
    chk("t4_resume", t, 8'h01);

    // 5: single-step pauses at each boundary
    step_mode = 1'b1;
    repeat (7) cyc();
    chk("t5_t7", t, 8'h80);
    cyc();
    retired++;
    chk("t5_pause", t, 8'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_halted", halted, 1'b0);
    chk("t5_count", instr_count, exp_cnt(retired));
    cyc();
    chk("t5_wait", t, 8'h00);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("t5_s0", t, 8'h01);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("t5_step_walk", t, 8'h01 << i);
    end
    cyc();
    retired++;
    chk("t5_pause2", t, 8'h00);
    step = 1'b1;
    halt_req = 1'b1;
    cyc();
    step = 1'b0;
    halt_req = 1'b0;
    chk("t5_halt_t", t, 8'h00);
    chk("t5_halt", halted, 1'b1);
    cyc();
    chk("t5_halt_stay", t, 8'h00);

    // 6: asynchronous reset mid-T4
    step_mode = 1'b0;
    run = 1'b1;
    cyc();
    run = 1'b0;
    repeat (4) cyc();
    chk("t6_t4", t, 8'h10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    cyc();
    rst = 1'b0;
    retired = 0;

    // Counter wrap: sixteen short instructions with a 4-bit counter
    run = 1'b1;
    cyc();
    run = 1'b0;
    short_cycle = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      repeat (6) cyc();
      retired++;
      if (k == 15) chk("wrap_15", instr_count, exp_cnt(retired));
    end
    chk("wrap_0", instr_count, exp_cnt(retired));
    chk("wrap_t", t, 8'h01);
    short_cycle = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
